program_fetch_unit: RTL

//   Parametrised, clocked successor to the combinational program ROM: a synchronous-read

---
 rtl/program_fetch_unit_pkg.sv | 18 +
 rtl/program_fetch_unit_fifo.sv | 58 +++++
 rtl/program_fetch_unit.sv | 93 +++++++++
 3 files changed

// File: rtl/program_fetch_unit_pkg.sv
// Shared definitions for the program fetch unit: NOP encoding, FSM states, default base
// address and the ROM image generator.
package program_fetch_unit_pkg;

  localparam logic [31:0] NOP_INSTR            = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_BASE_ADDRESS = 32'h0040_0000;

  typedef enum logic {
    FETCH = 1'b0,
    FAULT = 1'b1
  } fetch_state_e;

  // ROM contents: a fixed, index-unique instruction word per location.
  function automatic logic [31:0] rom_word(input logic [31:0] idx);
    return 32'hC0DE_0000 + idx;
  endfunction

endpackage

// File: rtl/program_fetch_unit_fifo.sv
// Prefetch FIFO: registered storage with push/pop/flush, occupancy level and head output.
// DEPTH must be a power of two so the pointers wrap naturally.
module program_fetch_unit_fifo #(
  parameter int unsigned      WIDTH       = 65,
  parameter int unsigned      DEPTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [$clog2(DEPTH+1)-1:0] level_o,
  output logic [WIDTH-1:0]           head_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
      level_d = level_q + LW'(push_i) - LW'(pop_i);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= RESET_VALUE;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      if (push_i && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign level_o = level_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/program_fetch_unit.sv
// Clocked instruction fetch: owns the fetch PC, range/alignment check and fetch FSM, and
// streams ROM words through a prefetch FIFO to decode with a valid/ready handshake.
module program_fetch_unit
  import program_fetch_unit_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH   = 32,
  parameter int unsigned           MEMORY_DEPTH = 64,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDRESS = DATA_WIDTH'(DEFAULT_BASE_ADDRESS),
  parameter int unsigned           FIFO_DEPTH   = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            Redirect_i,
  input  logic [DATA_WIDTH-1:0]           Redirect_Address_i,
  input  logic                            Instr_Ready_i,
  output logic                            Instr_Valid_o,
  output logic [DATA_WIDTH-1:0]           Instruction_o,
  output logic [DATA_WIDTH-1:0]           Instr_PC_o,
  output logic                            Fetch_Fault_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] Fifo_Level_o
);

  localparam int unsigned IW = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;
  localparam int unsigned LW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned EW = 2 * DATA_WIDTH + 1;
  localparam logic [EW-1:0] EMPTY_ENTRY = {1'b0, {DATA_WIDTH{1'b0}}, DATA_WIDTH'(NOP_INSTR)};

  fetch_state_e          state_q, state_d;
  logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [DATA_WIDTH-1:0] pc_offset;
  logic [IW-1:0]         rom_idx;
  logic                  fetch_fault;
  logic                  pop, push, can_issue;
  logic [EW-1:0]         push_data, head;
  logic [LW-1:0]         level;
  logic [DATA_WIDTH-1:0] rom [MEMORY_DEPTH];

  for (genvar g = 0; g < int'(MEMORY_DEPTH); g++) begin : g_rom
    assign rom[g] = DATA_WIDTH'(rom_word(32'(g)));
  end

  // Address check, issue decision and next fetch PC / state.
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    pc_offset   = fetch_pc_q - BASE_ADDRESS;
    rom_idx     = pc_offset[IW+1:2];
    fetch_fault = (fetch_pc_q[1:0] != 2'b00) || (fetch_pc_q < BASE_ADDRESS) ||
                  ((pc_offset >> 2) >= DATA_WIDTH'(MEMORY_DEPTH));
    pop         = Instr_Valid_o && Instr_Ready_i;
    can_issue   = (state_q == FETCH) && ((level < LW'(FIFO_DEPTH)) || pop);
    push        = can_issue && !Redirect_i;
    push_data   = fetch_fault ? {1'b1, fetch_pc_q, DATA_WIDTH'(NOP_INSTR)}
                              : {1'b0, fetch_pc_q, rom[rom_idx]};
    if (Redirect_i) begin
      state_d    = FETCH;
      fetch_pc_d = Redirect_Address_i;
    end else if (push) begin
      if (fetch_fault) state_d = FAULT;
      else             fetch_pc_d = fetch_pc_q + DATA_WIDTH'(4);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= FETCH;
      fetch_pc_q <= BASE_ADDRESS;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  program_fetch_unit_fifo #(
    .WIDTH       (EW),
    .DEPTH       (FIFO_DEPTH),
    .RESET_VALUE (EMPTY_ENTRY)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush_i (Redirect_i),
    .push_i  (push),
    .data_i  (push_data),
    .pop_i   (pop),
    .level_o (level),
    .head_o  (head)
  );

  assign Instr_Valid_o = (level != '0);
  assign Fifo_Level_o  = level;
  assign {Fetch_Fault_o, Instr_PC_o, Instruction_o} = head;

endmodule
